// File: rtl/rin_seq_gen.sv
// rin_seq_gen: stimulus transmitter for the a/b three-state recognizer.
// On an accepted start it steers the recognizer S0 -> S1 -> S2. It holds the
// recognizer in S2 for len cycles (or until abort), then returns it to S0
// through a 00 pattern. A shadow copy of the recognizer runs from this block's
// own a/b. The shadow output is compared live against the real recognizer's y.
module rin_seq_gen #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             y_obs,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             y_exp,
  output logic             err
);

  // Sequencer states.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_OPEN1 = 3'd1;
  localparam logic [2:0] ST_OPEN2 = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_CLOSE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Shadow recognizer states.
  localparam logic [1:0] SH_S0 = 2'd0;
  localparam logic [1:0] SH_S1 = 2'd1;
  localparam logic [1:0] SH_S2 = 2'd2;

  // The HOLD a/b pattern steps through three phases: 01, 10, 11.
  localparam logic [1:0] PH_01 = 2'd0;
  localparam logic [1:0] PH_10 = 2'd1;
  localparam logic [1:0] PH_11 = 2'd2;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [LEN_W-1:0] hold_cnt;
  logic [1:0]       phase;
  logic [1:0]       shadow;
  logic [1:0]       shadow_nxt;
  logic             accept;
  logic             hold_last;

  // A start counts only in IDLE. A start seen in DONE or while busy is dropped.
  assign accept = (state == ST_IDLE) && start;

  // HOLD ends on its final counted cycle. The counter never sits at zero inside HOLD,
  // but that case still exits so a corrupted count cannot trap the FSM.
  assign hold_last = (hold_cnt <= LEN_W'(1));

  // Next-state logic for the sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_OPEN1;
      ST_OPEN1: state_nxt = ST_OPEN2;
      ST_OPEN2: state_nxt = (hold_cnt != '0) ? ST_HOLD : ST_CLOSE;
      ST_HOLD:  if (abort || hold_last) state_nxt = ST_CLOSE;
      ST_CLOSE: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Hold counter: loaded on an accepted start and counted down in HOLD without wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (accept) begin
      hold_cnt <= len;
    end else if ((state == ST_HOLD) && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - LEN_W'(1);
    end
  end

  // HOLD pattern phase: restarts at 01 on every HOLD entry, then rotates 01 -> 10 -> 11.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= PH_01;
    end else if (state == ST_OPEN2) begin
      phase <= PH_01;
    end else if (state == ST_HOLD) begin
      phase <= (phase == PH_11) ? PH_01 : phase + 2'd1;
    end
  end

  // Moore output decode from the state and phase registers only.
  always_comb begin
    a    = 1'b1;
    b    = 1'b1;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_IDLE: begin
        a = 1'b1;
        b = 1'b1;
      end
      ST_OPEN1: begin
        a    = 1'b0;
        b    = 1'b1;
        busy = 1'b1;
      end
      ST_OPEN2: begin
        a    = 1'b1;
        b    = 1'b0;
        busy = 1'b1;
      end
      ST_HOLD: begin
        busy = 1'b1;
        case (phase)
          PH_01:   begin a = 1'b0; b = 1'b1; end
          PH_10:   begin a = 1'b1; b = 1'b0; end
          default: begin a = 1'b1; b = 1'b1; end
        endcase
      end
      ST_CLOSE: begin
        a    = 1'b0;
        b    = 1'b0;
        busy = 1'b1;
      end
      ST_DONE: begin
        a    = 1'b1;
        b    = 1'b1;
        done = 1'b1;
      end
      default: begin
        a = 1'b1;
        b = 1'b1;
      end
    endcase
  end

  // Shadow recognizer transition function, driven by this block's own a/b.
  always_comb begin
    shadow_nxt = shadow;
    case (shadow)
      SH_S0:   shadow_nxt = a ? SH_S0 : SH_S1;
      SH_S1:   shadow_nxt = b ? SH_S0 : SH_S2;
      SH_S2:   shadow_nxt = (a | b) ? SH_S2 : SH_S0;
      default: shadow_nxt = SH_S0;
    endcase
  end

  // Shadow recognizer state register. It shares reset with the real recognizer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) shadow <= SH_S0;
    else       shadow <= shadow_nxt;
  end

  assign y_exp = (shadow == SH_S2);

  // Sticky mismatch flag. It watches only while a sequence is active and clears on a new start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if ((busy | done) && (y_obs != y_exp)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rin_seq_gen.sv
// tb_rin_seq_gen: scoreboard bench for rin_seq_gen.
// The driver builds the expected per-cycle trace of each sequence from its
// a/b/y rules and queues one expected entry per cycle. A negedge monitor pops
// and compares these entries independently of the driver.
module tb_rin_seq_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] len;
  logic       abort;
  logic       y_obs;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       y_exp;
  logic       err;

  typedef struct packed {
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       y;
    logic       hold;
    logic [3:0] hidx;
  } exp_t;

  typedef struct packed {
    logic a;
    logic b;
    logic busy;
    logic done;
    logic y;
    logic err;
  } sb_t;

  exp_t future[$];
  sb_t  sbq[$];
  logic model_err;
  int   checks;
  int   passes;
  int   cyc;
  sb_t  mon_e;

  rin_seq_gen #(.LEN_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .len   (len),
    .abort (abort),
    .y_obs (y_obs),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y_exp (y_exp),
    .err   (err)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  function automatic exp_t mk(input logic ea, input logic eb, input logic ebusy,
                              input logic edone, input logic ey, input logic eh,
                              input logic [3:0] ei);
    exp_t e;
    e.a = ea; e.b = eb; e.busy = ebusy; e.done = edone;
    e.y = ey; e.hold = eh; e.hidx = ei;
    return e;
  endfunction

  function automatic sb_t idleSb(input logic e_err);
    sb_t e;
    e.a = 1'b1; e.b = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.y = 1'b0; e.err = e_err;
    return e;
  endfunction

  // Expected trace of a whole sequence, starting in the cycle after the accepting edge.
  task automatic appendSeq(input logic [3:0] ln);
    future.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
    future.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
    for (int i = 1; i <= int'(ln); i++) begin
      case ((i - 1) % 3)
        0:       future.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'(i)));
        1:       future.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'(i)));
        default: future.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'(i)));
      endcase
    end
    future.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0));
    future.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
  endtask

  // Compare the DUT outputs against one expected entry.
  task automatic checkOutput(input sb_t e, input string name);
    checks++;
    if ({a, b, busy, done, y_exp, err} === {e.a, e.b, e.busy, e.done, e.y, e.err}) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s cyc=%0d got a=%b b=%b busy=%b done=%b y_exp=%b err=%b want a=%b b=%b busy=%b done=%b y_exp=%b err=%b",
               name, cyc, a, b, busy, done, y_exp, err,
               e.a, e.b, e.busy, e.done, e.y, e.err);
    end
  endtask

  // Drive one clock cycle: pick this cycle's expectation, queue it, and set the inputs for the next edge.
  task automatic applyStimulus(input bit st, input logic [3:0] ln, input int abort_at,
                               input bit noise, input bit yforce);
    exp_t cur;
    sb_t  e;
    bit   ab_now;
    bit   idle_now;
    @(posedge clk);
    #1;
    if (future.size() != 0) cur = future.pop_front();
    else                    cur = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    idle_now = !cur.busy && !cur.done;
    ab_now = 1'b0;
    if (cur.hold) ab_now = (int'(cur.hidx) == abort_at);
    else if (noise) ab_now = ($urandom_range(0, 1) == 1);
    if (ab_now && cur.hold) begin
      while (future.size() != 0 && future[0].hold) void'(future.pop_front());
    end
    y_obs = (yforce && cur.hold) ? 1'b0 : cur.y;
    e.a = cur.a; e.b = cur.b; e.busy = cur.busy; e.done = cur.done;
    e.y = cur.y; e.err = model_err;
    sbq.push_back(e);
    if (st && idle_now) begin
      model_err = 1'b0;
      appendSeq(ln);
    end else if ((cur.busy || cur.done) && (y_obs != cur.y)) begin
      model_err = 1'b1;
    end
    start = st;
    len   = ln;
    abort = ab_now;
  endtask

  // Run one complete sequence from IDLE and follow it with gap idle cycles.
  task automatic runSeq(input logic [3:0] ln, input int abort_at, input bit spam,
                        input bit noise, input bit yforce, input int gap);
    int guard;
    applyStimulus(1'b1, ln, -1, noise, 1'b0);
    guard = 0;
    while (future.size() != 0 && guard < 64) begin
      applyStimulus(spam, 4'($urandom), abort_at, noise, yforce);
      guard++;
    end
    for (int i = 0; i < gap; i++) applyStimulus(1'b0, 4'($urandom), -1, noise, 1'b0);
  endtask

  // Assert reset partway through a cycle and expect the idle outputs at once.
  task automatic resetMid();
    #2;
    reset = 1'b1;
    #1;
    checkOutput(idleSb(1'b0), "reset_mid");
    sbq.delete();
    future.delete();
    model_err = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    y_obs = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compare the DUT against the oldest queued expectation once per cycle.
  always @(negedge clk) begin
    cyc++;
    if (!reset && sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      checkOutput(mon_e, "cycle");
    end
  end

  initial begin
    checks = 0; passes = 0; cyc = 0; model_err = 1'b0;
    reset = 1'b1; start = 1'b0; len = 4'd0; abort = 1'b0; y_obs = 1'b0;
    #1;
    checkOutput(idleSb(1'b0), "reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    checkOutput(idleSb(1'b0), "reset_held");
    reset = 1'b0;

    $display("[TB] idle after reset");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'($urandom), -1, 1'b1, 1'b0);

    $display("[TB] len=3");
    runSeq(4'd3, -1, 1'b0, 1'b0, 1'b0, 2);
    $display("[TB] len=0");
    runSeq(4'd0, -1, 1'b0, 1'b0, 1'b0, 2);
    $display("[TB] len=15 abort in 2nd hold cycle");
    runSeq(4'd15, 2, 1'b0, 1'b0, 1'b0, 2);
    $display("[TB] start pulsed while busy, len=2");
    runSeq(4'd2, -1, 1'b1, 1'b0, 1'b0, 2);
    $display("[TB] y_obs forced low during hold");
    runSeq(4'd4, -1, 1'b0, 1'b0, 1'b1, 3);
    runSeq(4'd1, -1, 1'b0, 1'b0, 1'b0, 2);

    $display("[TB] reset during hold");
    applyStimulus(1'b1, 4'd10, -1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, -1, 1'b0, 1'b0);
    resetMid();
    runSeq(4'd3, -1, 1'b0, 1'b0, 1'b0, 2);

    $display("[TB] randomized sequences");
    for (int n = 0; n < 24; n++) begin
      logic [3:0] ln_r;
      int         ab_r;
      ln_r = 4'($urandom);
      ab_r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, int'(ln_r) + 1)) : -1;
      runSeq(ln_r, ab_r, $urandom_range(0, 1) == 1, 1'b1,
             $urandom_range(0, 4) == 0, int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
